femto_mem_arbiter: RTL and testbench
====================================

Name: femto_mem_arbiter

Overview:
- Two-master, one-slave arbiter for the FemtoRV32 native memory bus (addr / wdata / wmask / rstrb / rbusy / wbusy).
- Shares one memory or peripheral port between the CPU (master 0) and a second requester such as a DMA or debug loader (master 1).
- Captures each master's single-cycle strobe into a request slot, then replays the granted request on the slave port.
- Holds the other master busy until its request is served. Arbitration is round-robin.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- RR_INIT, 1, reset value of last_grant; 1 means master 0 wins the first tie.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- m0_addr  in  ADDR_WIDTH  master 0 address; held stable by master while busy
- m0_wdata  in  32  master 0 write data
- m0_wmask  in  4  master 0 byte write mask; nonzero for one cycle = write strobe
- m0_rstrb  in  1  master 0 read strobe, one cycle
- m0_rdata  out  32  master 0 read data; valid while m0_rbusy low after a read
- m0_rbusy  out  1  master 0 read busy
- m0_wbusy  out  1  master 0 write busy
- m1_addr, m1_wdata, m1_wmask, m1_rstrb, m1_rdata, m1_rbusy, m1_wbusy  same as m0_*, for master 1
- s_addr  out  ADDR_WIDTH  slave address, registered
- s_wdata  out  32  slave write data, registered
- s_wmask  out  4  slave write strobe/mask, one-cycle pulse
- s_rstrb  out  1  slave read strobe, one-cycle pulse
- s_rdata  in  32  slave read data
- s_rbusy  in  1  slave read busy
- s_wbusy  in  1  slave write busy
- arb_grant  out  1  index of master currently or last granted

Behaviour:
- Reset (reset==0 at posedge): both slots empty, state IDLE, s_rstrb=0, s_wmask=0, s_addr=0, s_wdata=0, m0/m1_rdata=0, arb_grant=0, last_grant=RR_INIT.
- Slot capture, per master: a strobe is m_rstrb | (|m_wmask).
  - If the slot is empty, latch addr, wdata, wmask and op (WR if wmask nonzero, else RD) and set pending.
  - If rstrb and wmask are asserted together, the write wins and the read is dropped.
  - A strobe while the slot is already pending is a protocol violation: it is ignored and the slot is unchanged.
- Busy outputs are combinational:
  - mX_rbusy = (pending & op==RD) | mX_rstrb
  - mX_wbusy = (pending & op==WR) | (|mX_wmask)
  - Busy is therefore high in the strobe cycle itself. The CPU samples wbusy in the same cycle its wmask is high.
- FSM states are IDLE, ISSUE, WAIT.
  - IDLE: if no slot is pending, stay. If exactly one is pending, grant it. If both are pending, grant !last_grant.
  - On grant: register s_addr/s_wdata from the slot, register s_rstrb=1 (RD) or s_wmask=slot mask (WR), set arb_grant, go to ISSUE.
  - ISSUE: the strobe is visible on the slave for exactly this cycle. Clear s_rstrb/s_wmask at the end of the cycle. Slave busy is not sampled here. Go to WAIT.
  - WAIT: hold s_addr/s_wdata. When !s_rbusy & !s_wbusy: on RD, latch s_rdata into mX_rdata; clear the granted slot's pending; last_grant <= arb_grant; go to IDLE.
- Latency: a master strobe in cycle T with a zero-wait slave gives slave strobe in T+2, completion sampled in T+3, and master busy low with rdata valid in T+4. Each slave wait cycle adds one.
- mX_rdata holds its value until that master's next read completes; writes do not modify it.
- The non-granted master may strobe at any time into its empty slot. Capture proceeds in parallel with the other master's transaction.
- A master may re-strobe in the first cycle its busy is low. The slot is empty that cycle, so there are no back-to-back hazards.
- Reset mid-transaction: all state is cleared immediately and slave strobes drop. An in-flight slave access is abandoned and its completion is not forwarded.

Decomposition:
- Package femto_bus_pkg: FSM state encoding (IDLE/ISSUE/WAIT), op constants OP_RD/OP_WR, DATA_W=32, MASK_W=4.
- Sub-module femto_req_slot: one request capture buffer (addr, wdata, mask, op, pending, busy generation, clear input). Instantiated twice.

Test Plan:
- Single read: m0_rstrb at T with addr 0x100; slave returns 0xDEADBEEF with 0 waits -> s_rstrb only in T+2, s_addr=0x100; m0_rbusy high T..T+3, low at T+4; m0_rdata=0xDEADBEEF.
- Byte write: m1_wmask=4'b0100, wdata=0x00AA0000, addr 0x204 -> s_wmask=4'b0100 for one cycle; m1_wbusy high in the strobe cycle and until completion; m1_rdata unchanged.
- Simultaneous strobes after reset: m0 read and m1 write in the same cycle -> m0 served first, then m1 issued in the IDLE cycle after m0 completes; arb_grant 0 then 1.
- Round-robin fairness: both masters re-strobe continuously -> grants alternate 0,1,0,1; neither master is starved for more than one transaction.
- Slave wait states: s_rbusy held high 5 cycles after s_rstrb -> master busy extends by exactly 5 cycles; no second s_rstrb is issued.
- Reset mid-WAIT: assert reset with m0 pending and s_rbusy high -> next cycle all busies low (no strobes), slots empty, s_rstrb=0; a later m0 strobe is served normally.

Source files
------------

// File: rtl/femto_bus_pkg.sv
// Shared definitions for the FemtoRV32 native-bus arbiter slice.
// Provides the arbiter FSM encoding, the request op encoding and bus widths.
// No ports; imported by femto_req_slot and femto_mem_arbiter.
package femto_bus_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/femto_req_slot.sv
// Single-entry request capture buffer for one master of the native bus.
// Latency: strobe captured at the end of its cycle; busy is combinational (high in the strobe cycle).
// Backpressure: busy stays high while the slot is pending; a strobe into a full slot is ignored.
// Ports: clk/reset; addr/wdata/wmask/rstrb from the master; clear from the arbiter;
//        pending, slot_addr/slot_wdata/slot_wmask/slot_op to the arbiter; rbusy/wbusy to the master.
module femto_req_slot
  import femto_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [MASK_W-1:0]     wmask,
  input  logic                  rstrb,
  input  logic                  clear,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] slot_addr,
  output logic [DATA_W-1:0]     slot_wdata,
  output logic [MASK_W-1:0]     slot_wmask,
  output logic                  slot_op,
  output logic                  rbusy,
  output logic                  wbusy
);

  logic is_wr;
  logic strobe;

  assign is_wr  = |wmask;
  assign strobe = rstrb | is_wr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending    <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      slot_wmask <= '0;
      slot_op    <= OP_RD;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (!pending && strobe) begin
      // A write strobe overrides a simultaneous read strobe.
      pending    <= 1'b1;
      slot_addr  <= addr;
      slot_wdata <= wdata;
      slot_wmask <= wmask;
      slot_op    <= is_wr ? OP_WR : OP_RD;
    end
  end

  // The CPU samples busy in the strobe cycle itself, so the raw strobe is folded in.
  assign rbusy = (pending && (slot_op == OP_RD)) || rstrb;
  assign wbusy = (pending && (slot_op == OP_WR)) || is_wr;

endmodule

// File: rtl/femto_mem_arbiter.sv
// Round-robin two-master to one-slave arbiter for the FemtoRV32 native memory bus.
// Latency: master strobe at T -> slave strobe at T+2 -> completion sampled T+3 -> master free T+4 (+1 per slave wait).
// Backpressure: slave rbusy/wbusy stall WAIT; masters are held busy until their own request completes.
// Ports: m0_*/m1_* master buses (addr, wdata, wmask, rstrb in; rdata, rbusy, wbusy out);
//        s_* registered slave bus (addr, wdata, wmask, rstrb out; rdata, rbusy, wbusy in); arb_grant out.
module femto_mem_arbiter
  import femto_bus_pkg::*;
#(
  parameter int   ADDR_WIDTH = 32,
  parameter logic RR_INIT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [MASK_W-1:0]     m0_wmask,
  input  logic                  m0_rstrb,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_rbusy,
  output logic                  m0_wbusy,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [MASK_W-1:0]     m1_wmask,
  input  logic                  m1_rstrb,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_rbusy,
  output logic                  m1_wbusy,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [MASK_W-1:0]     s_wmask,
  output logic                  s_rstrb,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic                  s_rbusy,
  input  logic                  s_wbusy,
  output logic                  arb_grant
);

  state_t                state, state_next;
  logic                  last_grant;
  logic                  do_grant, done, grant_sel;
  logic [1:0]            pend, clear;
  logic [ADDR_WIDTH-1:0] addr0, addr1, sel_addr;
  logic [DATA_W-1:0]     wdata0, wdata1, sel_wdata;
  logic [MASK_W-1:0]     mask0, mask1, sel_mask;
  logic                  op0, op1, sel_op, cur_op;

  femto_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot0 (
    .clk(clk), .reset(reset), .addr(m0_addr), .wdata(m0_wdata), .wmask(m0_wmask),
    .rstrb(m0_rstrb), .clear(clear[0]), .pending(pend[0]), .slot_addr(addr0),
    .slot_wdata(wdata0), .slot_wmask(mask0), .slot_op(op0),
    .rbusy(m0_rbusy), .wbusy(m0_wbusy)
  );

  femto_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot1 (
    .clk(clk), .reset(reset), .addr(m1_addr), .wdata(m1_wdata), .wmask(m1_wmask),
    .rstrb(m1_rstrb), .clear(clear[1]), .pending(pend[1]), .slot_addr(addr1),
    .slot_wdata(wdata1), .slot_wmask(mask1), .slot_op(op1),
    .rbusy(m1_rbusy), .wbusy(m1_wbusy)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    done       = 1'b0;
    // On a tie the master that did not win last time goes next.
    grant_sel  = (pend == 2'b11) ? ~last_grant : pend[1];
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          do_grant   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      // Slave busy is meaningless while the strobe is still on the bus.
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!s_rbusy && !s_wbusy) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = grant_sel ? addr1  : addr0;
    sel_wdata = grant_sel ? wdata1 : wdata0;
    sel_mask  = grant_sel ? mask1  : mask0;
    sel_op    = grant_sel ? op1    : op0;
    cur_op    = arb_grant ? op1    : op0;
    clear     = {done && arb_grant, done && !arb_grant};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wmask    <= '0;
      s_rstrb    <= 1'b0;
      arb_grant  <= 1'b0;
      last_grant <= RR_INIT;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (do_grant) begin
        arb_grant <= grant_sel;
        s_addr    <= sel_addr;
        s_wdata   <= sel_wdata;
        s_rstrb   <= (sel_op == OP_RD);
        s_wmask   <= (sel_op == OP_WR) ? sel_mask : '0;
      end else begin
        // Strobes are single-cycle pulses: only the grant cycle sets them.
        s_rstrb <= 1'b0;
        s_wmask <= '0;
      end
      if (done) begin
        last_grant <= arb_grant;
        if (cur_op == OP_RD) begin
          if (arb_grant) m1_rdata <= s_rdata;
          else           m0_rdata <= s_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_femto_mem_arbiter.sv
// Self-checking bench for femto_mem_arbiter: cycle table, hand-written corner sequences,
// and randomized two-master traffic checked against a transaction-level memory model.
module tb_femto_mem_arbiter;
  import femto_bus_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [31:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]    m0_wmask, m1_wmask, s_wmask;
  logic          m0_rstrb, m1_rstrb, m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic          s_rstrb, s_rbusy, s_wbusy, arb_grant;

  always #5 clk = ~clk;

  femto_mem_arbiter #(.ADDR_WIDTH(AW), .RR_INIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy), .arb_grant(arb_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic        m0r;
    logic [3:0]  m0m;
    logic        m1r;
    logic [3:0]  m1m;
    logic        srb;
    logic [31:0] srd;
    logic        e_srstrb;
    logic [3:0]  e_swmask;
    logic        e_grant;
    logic [3:0]  e_busy;    // {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}
    logic [31:0] e_saddr;
    logic [31:0] e_swdata;
    logic [31:0] e_m0rd;
    logic [31:0] e_m1rd;
  } vec_t;

  vec_t tbl [18];

  // Transaction-level model state for randomized traffic.
  logic [31:0] ref_mem [64];
  logic [31:0] slv_mem [64];

  task automatic run_traffic(input int ncyc, input int pct, input int maxw, input bit rr);
    bit          vld [2];
    bit          iss [2];
    bit          wr  [2];
    bit          stb [2];
    bit          rs  [2];
    logic [31:0] a   [2];
    logic [31:0] wd  [2];
    logic [3:0]  mk  [2];
    logic [31:0] ex  [2];
    int          age [2];
    int          sl_wait, sl_idx, last_g, cyc, ndone, idx, g;
    bit          sl_wr, bsy;
    sl_wait = 0; sl_idx = 0; last_g = -1; cyc = 0; ndone = 0; sl_wr = 1'b0;
    for (int m = 0; m < 2; m++) begin
      vld[m] = 1'b0; iss[m] = 1'b0; wr[m] = 1'b0; age[m] = 0;
      a[m] = '0; wd[m] = '0; mk[m] = '0; ex[m] = '0;
    end
    while (cyc < ncyc || ((vld[0] || vld[1]) && cyc < ncyc + 400)) begin
      @(negedge clk);
      // Slave: hold busy for the chosen number of wait cycles after each strobe.
      s_rbusy = (sl_wait > 0) && !sl_wr;
      s_wbusy = (sl_wait > 0) && sl_wr;
      if (sl_wait > 0) sl_wait--;
      s_rdata = slv_mem[sl_idx];
      for (int m = 0; m < 2; m++) begin
        stb[m] = 1'b0;
        rs[m]  = 1'b0;
        if (!vld[m] && cyc < ncyc && $urandom_range(0, 99) < pct) begin
          idx    = m * 32 + int'($urandom_range(0, 31));
          a[m]   = 32'(idx) << 2;
          wr[m]  = ($urandom_range(0, 1) == 1);
          wd[m]  = $urandom;
          mk[m]  = 4'($urandom_range(1, 15));
          stb[m] = 1'b1;
          rs[m]  = !wr[m] || ($urandom_range(0, 3) == 0);
          vld[m] = 1'b1;
          age[m] = 0;
          if (wr[m]) ref_mem[idx] = merge(ref_mem[idx], wd[m], mk[m]);
          else       ex[m] = ref_mem[idx];
        end
      end
      m0_addr = a[0]; m0_wdata = wd[0]; m0_rstrb = rs[0]; m0_wmask = (stb[0] && wr[0]) ? mk[0] : 4'h0;
      m1_addr = a[1]; m1_wdata = wd[1]; m1_rstrb = rs[1]; m1_wmask = (stb[1] && wr[1]) ? mk[1] : 4'h0;
      #1;
      if (s_rstrb || s_wmask != 4'h0) begin
        g = int'(arb_grant);
        chk("rand_grant_owner", 32'(vld[g] && !iss[g]), 32'd1);
        chk("rand_s_addr", s_addr, a[g]);
        chk("rand_s_rstrb", 32'(s_rstrb), 32'(!wr[g]));
        chk("rand_s_wmask", 32'(s_wmask), wr[g] ? 32'(mk[g]) : 32'd0);
        if (wr[g]) chk("rand_s_wdata", s_wdata, wd[g]);
        if (rr && last_g >= 0) chk("rr_alternate", 32'(g != last_g), 32'd1);
        iss[g] = 1'b1;
        last_g = g;
        if (s_wmask != 4'h0) slv_mem[s_addr[7:2]] = merge(slv_mem[s_addr[7:2]], s_wdata, s_wmask);
        sl_idx  = int'(s_addr[7:2]);
        sl_wr   = (s_wmask != 4'h0);
        sl_wait = int'($urandom_range(0, maxw));
      end
      for (int m = 0; m < 2; m++) begin
        if (vld[m] && !stb[m]) begin
          age[m]++;
          bsy = (m == 1) ? (m1_rbusy || m1_wbusy) : (m0_rbusy || m0_wbusy);
          if (!bsy) begin
            chk("rand_served_before_free", 32'(iss[m]), 32'd1);
            if (!wr[m]) chk((m == 1) ? "rand_m1_rdata" : "rand_m0_rdata",
                            (m == 1) ? m1_rdata : m0_rdata, ex[m]);
            vld[m] = 1'b0;
            iss[m] = 1'b0;
            ndone++;
          end else if (age[m] > 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand_timeout: master %0d busy for %0d cycles, required completion", m, age[m]);
            vld[m] = 1'b0;
            iss[m] = 1'b0;
          end
        end
      end
      cyc++;
    end
    if (vld[0] || vld[1]) begin
      n_tests++;
      n_fail++;
      $display("FAIL rand_drain: requests still outstanding m0=%0d m1=%0d, required none", vld[0], vld[1]);
    end
    chk("rand_progress", 32'(ndone > ncyc / 20), 32'd1);
    m0_rstrb = 1'b0; m0_wmask = 4'h0; m1_rstrb = 1'b0; m1_wmask = 4'h0;
    s_rbusy = 1'b0; s_wbusy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // m0 reads 0x100 and m1 writes 0x204 together, then m0 reads with 5 slave wait cycles.
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'h4, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0, 4'b1001, 32'h000, 32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0, 4'b1001, 32'h000, 32'h0,        32'h0,        32'h0};
    tbl[2]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1, 4'h0, 1'b0, 4'b1001, 32'h100, 32'h0,        32'h0,        32'h0};
    tbl[3]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0, 4'b1001, 32'h100, 32'h0,        32'h0,        32'h0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, 1'b0, 4'b0001, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h4, 1'b1, 4'b0001, 32'h204, 32'h00AA0000, 32'hDEADBEEF, 32'h0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, 1'b1, 4'b0001, 32'h204, 32'h00AA0000, 32'hDEADBEEF, 32'h0};
    tbl[7]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, 1'b1, 4'b0000, 32'h204, 32'h00AA0000, 32'hDEADBEEF, 32'h0};
    tbl[8]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h12345678, 1'b0, 4'h0, 1'b1, 4'b1000, 32'h204, 32'h00AA0000, 32'hDEADBEEF, 32'h0};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h12345678, 1'b0, 4'h0, 1'b1, 4'b1000, 32'h204, 32'h00AA0000, 32'hDEADBEEF, 32'h0};
    tbl[10] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h12345678, 1'b1, 4'h0, 1'b0, 4'b1000, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0};
    for (int i = 11; i < 16; i++)
      tbl[i] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 32'h12345678, 1'b0, 4'h0, 1'b0, 4'b1000, 32'h100, 32'h0,      32'hDEADBEEF, 32'h0};
    tbl[16] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h12345678, 1'b0, 4'h0, 1'b0, 4'b1000, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0};
    tbl[17] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h12345678, 1'b0, 4'h0, 1'b0, 4'b0000, 32'h100, 32'h0,        32'h12345678, 32'h0};

    reset = 1'b0;
    m0_addr = 32'h100; m0_wdata = 32'h0; m0_wmask = 4'h0; m0_rstrb = 1'b0;
    m1_addr = 32'h204; m1_wdata = 32'h00AA0000; m1_wmask = 4'h0; m1_rstrb = 1'b0;
    s_rdata = 32'h0; s_rbusy = 1'b0; s_wbusy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_s_rstrb", 32'(s_rstrb), 32'd0);
    chk("reset_s_wmask", 32'(s_wmask), 32'd0);
    chk("reset_s_addr", s_addr, 32'd0);
    chk("reset_s_wdata", s_wdata, 32'd0);
    chk("reset_grant", 32'(arb_grant), 32'd0);
    chk("reset_busy", 32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}), 32'd0);
    chk("reset_rdata", m0_rdata | m1_rdata, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      m0_rstrb = tbl[i].m0r; m0_wmask = tbl[i].m0m;
      m1_rstrb = tbl[i].m1r; m1_wmask = tbl[i].m1m;
      s_rbusy  = tbl[i].srb; s_rdata  = tbl[i].srd;
      #1;
      chk($sformatf("tbl%0d_s_rstrb", i), 32'(s_rstrb), 32'(tbl[i].e_srstrb));
      chk($sformatf("tbl%0d_s_wmask", i), 32'(s_wmask), 32'(tbl[i].e_swmask));
      chk($sformatf("tbl%0d_grant", i),   32'(arb_grant), 32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_busy", i),    32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_s_addr", i),  s_addr, tbl[i].e_saddr);
      chk($sformatf("tbl%0d_s_wdata", i), s_wdata, tbl[i].e_swdata);
      chk($sformatf("tbl%0d_m0_rdata", i), m0_rdata, tbl[i].e_m0rd);
      chk($sformatf("tbl%0d_m1_rdata", i), m1_rdata, tbl[i].e_m1rd);
    end

    // Reset while a read is stalled in WAIT: the access is abandoned.
    @(negedge clk); m0_rstrb = 1'b1; m0_addr = 32'h40; s_rdata = 32'h0BAD0BAD;
    @(negedge clk); m0_rstrb = 1'b0;
    @(negedge clk); #1 chk("rst_issue_pulse", 32'(s_rstrb), 32'd1);
    @(negedge clk); s_rbusy = 1'b1; #1 chk("rst_wait_busy", 32'(m0_rbusy), 32'd1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_busy", 32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}), 32'd0);
    chk("rst_mid_s_rstrb", 32'(s_rstrb), 32'd0);
    chk("rst_mid_grant", 32'(arb_grant), 32'd0);
    chk("rst_mid_m0_rdata", m0_rdata, 32'd0);
    reset = 1'b1; s_rbusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rst_after_no_strobe", 32'(s_rstrb), 32'd0);
      chk("rst_after_m0_free", 32'(m0_rbusy), 32'd0);
      chk("rst_after_no_forward", m0_rdata, 32'd0);
    end

    // Fresh read after reset; a second strobe while pending must be ignored.
    @(negedge clk); m0_addr = 32'h40; m0_rstrb = 1'b1; s_rdata = 32'hCAFEF00D;
    #1 chk("post_T_rbusy", 32'(m0_rbusy), 32'd1);
    @(negedge clk); m0_rstrb = 1'b0; m0_addr = 32'h80; m0_wmask = 4'hF; m0_wdata = 32'h11111111;
    #1 chk("post_T1_viol_wbusy", 32'(m0_wbusy), 32'd1);
    @(negedge clk); m0_wmask = 4'h0;
    #1;
    chk("post_T2_s_rstrb", 32'(s_rstrb), 32'd1);
    chk("post_T2_s_wmask", 32'(s_wmask), 32'd0);
    chk("post_T2_s_addr", s_addr, 32'h40);
    @(negedge clk); #1;
    chk("post_T3_s_rstrb", 32'(s_rstrb), 32'd0);
    chk("post_T3_rbusy", 32'(m0_rbusy), 32'd1);
    @(negedge clk); #1;
    chk("post_T4_busy", 32'({m0_rbusy, m0_wbusy}), 32'd0);
    chk("post_T4_rdata", m0_rdata, 32'hCAFEF00D);
    @(negedge clk); #1;
    chk("post_T5_no_write", 32'(s_wmask), 32'd0);

    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    run_traffic(1500, 30, 4, 1'b0);
    run_traffic(150, 100, 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
